// File: rtl/wide_add_pkg.sv
// Shared constants, FSM encoding and sizing helper for the wide add sequencer.

package wide_add_pkg;

   localparam int SLICE_W = 16;

   typedef logic [1:0] state_t;

   localparam state_t S_IDLE = 2'd0;
   localparam state_t S_RUN  = 2'd1;
   localparam state_t S_DONE = 2'd2;

   // Slice index needs at least one bit, even for a single-slice build.
   function automatic int idx_w(input int words);
      return (words > 1) ? $clog2(words) : 1;
   endfunction

endpackage

// File: rtl/wide_add_sequencer_settle_timer.sv
// Counts the cycles a slice has been held on the adder; done_o marks the
// cycle whose closing edge may sample the adder outputs.

module wide_add_sequencer_settle_timer #(
   parameter int SETTLE = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic clear_i,
   output logic done_o
);

   localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CW-1:0] LAST = CW'(SETTLE - 1);

   logic [CW-1:0] cnt_q;

   assign done_o = !clear_i && (cnt_q == LAST);

   // NOTE: sequential state uses non-blocking assignments only, so every
   // flop samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (clear_i || done_o) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/wide_add_sequencer.sv
// Feeds a 16-bit ripple adder one slice per step to build a WORDS*16-bit add.
// Optional feature macro: ADD_SUB_EN (adds in_sub for A-B).

module wide_add_sequencer
   import wide_add_pkg::*;
#(
   parameter int WORDS  = 4,
   parameter int SETTLE = 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [SLICE_W*WORDS-1:0]   in_a,
   input  logic [SLICE_W*WORDS-1:0]   in_b,
   input  logic                       in_cin,
`ifdef ADD_SUB_EN
   input  logic                       in_sub,
`endif
   output logic [SLICE_W-1:0]         add_a,
   output logic [SLICE_W-1:0]         add_b,
   output logic                       add_cin,
   input  logic [SLICE_W-1:0]         add_sum,
   input  logic                       add_cout,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [SLICE_W*WORDS-1:0]   out_sum,
   output logic                       out_cout
);

   localparam int W  = SLICE_W * WORDS;
   localparam int IW = idx_w(WORDS);

   state_t              state_q, state_d;
   logic [W-1:0]        a_q, a_d;
   logic [W-1:0]        b_q, b_d;
   logic [SLICE_W-1:0]  add_a_q, add_a_d;
   logic [SLICE_W-1:0]  add_b_q, add_b_d;
   logic                add_cin_q, add_cin_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic [W-1:0]        sum_q, sum_d;
   logic                cout_q, cout_d;
   logic [W-1:0]        b_src;
   logic                cin_src;
   logic                slice_done;

`ifdef ADD_SUB_EN
   // Subtraction is A + ~B + 1; B is stored pre-inverted so each slice loads as-is.
   assign b_src   = in_sub ? ~in_b : in_b;
   assign cin_src = in_sub ? 1'b1 : in_cin;
`else
   assign b_src   = in_b;
   assign cin_src = in_cin;
`endif

   wide_add_sequencer_settle_timer #(
      .SETTLE (SETTLE)
   ) u_timer (
      .clk     (clk),
      .reset   (reset),
      .clear_i (state_q != S_RUN),
      .done_o  (slice_done)
   );

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      add_a_d   = add_a_q;
      add_b_d   = add_b_q;
      add_cin_d = add_cin_q;
      idx_d     = idx_q;
      sum_d     = sum_q;
      cout_d    = cout_q;

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               a_d       = in_a;
               b_d       = b_src;
               add_a_d   = in_a[SLICE_W-1:0];
               add_b_d   = b_src[SLICE_W-1:0];
               add_cin_d = cin_src;
               idx_d     = '0;
               state_d   = S_RUN;
            end
         end
         S_RUN: begin
            if (slice_done) begin
               sum_d[int'(idx_q)*SLICE_W +: SLICE_W] = add_sum;
               if (idx_q == IW'(WORDS - 1)) begin
                  cout_d  = add_cout;
                  state_d = S_DONE;
               end else begin
                  // Operand registers shift down so the next slice is always the low word.
                  a_d       = a_q >> SLICE_W;
                  b_d       = b_q >> SLICE_W;
                  add_a_d   = a_d[SLICE_W-1:0];
                  add_b_d   = b_d[SLICE_W-1:0];
                  add_cin_d = add_cout;
                  idx_d     = idx_q + 1'b1;
               end
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         a_q       <= '0;
         b_q       <= '0;
         add_a_q   <= '0;
         add_b_q   <= '0;
         add_cin_q <= 1'b0;
         idx_q     <= '0;
         sum_q     <= '0;
         cout_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         add_a_q   <= add_a_d;
         add_b_q   <= add_b_d;
         add_cin_q <= add_cin_d;
         idx_q     <= idx_d;
         sum_q     <= sum_d;
         cout_q    <= cout_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign add_a     = add_a_q;
   assign add_b     = add_b_q;
   assign add_cin   = add_cin_q;
   assign out_sum   = sum_q;
   assign out_cout  = cout_q;

endmodule
